// File: rtl/config_pkg.sv
// Elaborated CVA6 configuration type plus the word map shared by firmware, the debug module and cva6_cfg_reader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package config_pkg;

    // Region rule vectors hold up to 16 rules, 64 bits per rule.
    typedef struct packed {
        logic [31:0]   XLEN;
        logic          RVA;
        logic          RVB;
        logic          RVC;
        logic          RVD;
        logic          RVF;
        logic          RVH;
        logic          RVS;
        logic          RVU;
        logic          RVV;
        logic [31:0]   VLEN;
        logic [31:0]   IcacheByteSize;
        logic [31:0]   IcacheSetAssoc;
        logic [31:0]   IcacheLineWidth;
        logic [31:0]   DcacheByteSize;
        logic [31:0]   DcacheSetAssoc;
        logic [31:0]   DcacheLineWidth;
        logic [31:0]   NrPMPEntries;
        logic [31:0]   NrScoreboardEntries;
        logic [31:0]   NrNonIdempotentRules;
        logic [1023:0] NonIdempotentAddrBase;
        logic [1023:0] NonIdempotentLength;
        logic [31:0]   NrExecuteRegionRules;
        logic [1023:0] ExecuteRegionAddrBase;
        logic [1023:0] ExecuteRegionLength;
        logic [31:0]   NrCachedRegionRules;
        logic [1023:0] CachedRegionAddrBase;
        logic [1023:0] CachedRegionLength;
        logic [63:0]   HaltAddress;
        logic [63:0]   ExceptionAddress;
        logic [63:0]   DmBaseAddress;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

    // Word indices
    localparam logic [7:0] CFG_RD_XLEN         = 8'h00;
    localparam logic [7:0] CFG_RD_ISA          = 8'h01;
    localparam logic [7:0] CFG_RD_VLEN         = 8'h02;
    localparam logic [7:0] CFG_RD_ICACHE_SIZE  = 8'h03;
    localparam logic [7:0] CFG_RD_ICACHE_ASSOC = 8'h04;
    localparam logic [7:0] CFG_RD_ICACHE_LINE  = 8'h05;
    localparam logic [7:0] CFG_RD_DCACHE_SIZE  = 8'h06;
    localparam logic [7:0] CFG_RD_DCACHE_ASSOC = 8'h07;
    localparam logic [7:0] CFG_RD_DCACHE_LINE  = 8'h08;
    localparam logic [7:0] CFG_RD_NR_PMP       = 8'h09;
    localparam logic [7:0] CFG_RD_NR_SB        = 8'h0A;
    localparam logic [7:0] CFG_RD_NR_RULES     = 8'h0B;
    localparam logic [7:0] CFG_RD_HALT_ADDR    = 8'h0C;
    localparam logic [7:0] CFG_RD_EXC_ADDR     = 8'h0D;
    localparam logic [7:0] CFG_RD_DM_BASE      = 8'h0E;
    localparam logic [7:0] CFG_RD_NONIDEM_BASE = 8'h10;
    localparam logic [7:0] CFG_RD_EXEC_BASE    = 8'h30;
    localparam logic [7:0] CFG_RD_CACHED_BASE  = 8'h50;
    localparam logic [7:0] CFG_RD_REGION_END   = 8'h70;

    // misa letter positions; I is always reported since every hart has the base integer ISA
    localparam int unsigned ISA_A_BIT = 0;
    localparam int unsigned ISA_B_BIT = 1;
    localparam int unsigned ISA_C_BIT = 2;
    localparam int unsigned ISA_D_BIT = 3;
    localparam int unsigned ISA_F_BIT = 5;
    localparam int unsigned ISA_H_BIT = 7;
    localparam int unsigned ISA_I_BIT = 8;
    localparam int unsigned ISA_S_BIT = 18;
    localparam int unsigned ISA_U_BIT = 20;
    localparam int unsigned ISA_V_BIT = 21;

    typedef enum logic {
        RD_IDLE,
        RD_STREAM
    } rd_state_e;

endpackage

// File: rtl/cva6_cfg_word_lut.sv
// Combinational word index -> {data, err} lookup over the elaborated configuration.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; ports addr_i (word index), data_o (zero-extended word), err_o (unmapped/unused).
module cva6_cfg_word_lut
    import config_pkg::*;
#(
    parameter cva6_cfg_t CVA6Cfg = cva6_cfg_empty
) (
    input  logic [7:0]  addr_i,
    output logic [63:0] data_o,
    output logic        err_o
);

    logic        in_region;
    logic [6:0]  off;
    logic [1:0]  grp;
    logic [3:0]  rule;
    logic [31:0] nr;
    logic [63:0] base;
    logic [63:0] len;

    // Region window 0x10..0x6F: 32 words per rule class, base/length interleaved.
    assign in_region = (addr_i >= CFG_RD_NONIDEM_BASE) && (addr_i < CFG_RD_REGION_END);
    assign off       = addr_i[6:0] - CFG_RD_NONIDEM_BASE[6:0];
    assign grp       = off[6:5];
    assign rule      = off[4:1];

    always_comb begin
        nr   = '0;
        base = '0;
        len  = '0;
        case (grp)
            2'd0: begin
                nr   = CVA6Cfg.NrNonIdempotentRules;
                base = CVA6Cfg.NonIdempotentAddrBase[64*rule +: 64];
                len  = CVA6Cfg.NonIdempotentLength[64*rule +: 64];
            end
            2'd1: begin
                nr   = CVA6Cfg.NrExecuteRegionRules;
                base = CVA6Cfg.ExecuteRegionAddrBase[64*rule +: 64];
                len  = CVA6Cfg.ExecuteRegionLength[64*rule +: 64];
            end
            2'd2: begin
                nr   = CVA6Cfg.NrCachedRegionRules;
                base = CVA6Cfg.CachedRegionAddrBase[64*rule +: 64];
                len  = CVA6Cfg.CachedRegionLength[64*rule +: 64];
            end
            default: ;
        endcase
    end

    always_comb begin
        data_o = '0;
        err_o  = 1'b0;
        if (in_region) begin
            // Rule slots past the configured count exist in the vector but are not meaningful.
            if ({28'd0, rule} < nr) data_o = off[0] ? len : base;
            else                    err_o  = 1'b1;
        end else begin
            case (addr_i)
                CFG_RD_XLEN:         data_o = {32'd0, CVA6Cfg.XLEN};
                CFG_RD_ISA: begin
                    data_o[ISA_A_BIT] = CVA6Cfg.RVA;
                    data_o[ISA_B_BIT] = CVA6Cfg.RVB;
                    data_o[ISA_C_BIT] = CVA6Cfg.RVC;
                    data_o[ISA_D_BIT] = CVA6Cfg.RVD;
                    data_o[ISA_F_BIT] = CVA6Cfg.RVF;
                    data_o[ISA_H_BIT] = CVA6Cfg.RVH;
                    data_o[ISA_I_BIT] = 1'b1;
                    data_o[ISA_S_BIT] = CVA6Cfg.RVS;
                    data_o[ISA_U_BIT] = CVA6Cfg.RVU;
                    data_o[ISA_V_BIT] = CVA6Cfg.RVV;
                end
                CFG_RD_VLEN:         data_o = {32'd0, CVA6Cfg.VLEN};
                CFG_RD_ICACHE_SIZE:  data_o = {32'd0, CVA6Cfg.IcacheByteSize};
                CFG_RD_ICACHE_ASSOC: data_o = {32'd0, CVA6Cfg.IcacheSetAssoc};
                CFG_RD_ICACHE_LINE:  data_o = {32'd0, CVA6Cfg.IcacheLineWidth};
                CFG_RD_DCACHE_SIZE:  data_o = {32'd0, CVA6Cfg.DcacheByteSize};
                CFG_RD_DCACHE_ASSOC: data_o = {32'd0, CVA6Cfg.DcacheSetAssoc};
                CFG_RD_DCACHE_LINE:  data_o = {32'd0, CVA6Cfg.DcacheLineWidth};
                CFG_RD_NR_PMP:       data_o = {32'd0, CVA6Cfg.NrPMPEntries};
                CFG_RD_NR_SB:        data_o = {32'd0, CVA6Cfg.NrScoreboardEntries};
                CFG_RD_NR_RULES:     data_o = {40'd0,
                                               CVA6Cfg.NrCachedRegionRules[7:0],
                                               CVA6Cfg.NrExecuteRegionRules[7:0],
                                               CVA6Cfg.NrNonIdempotentRules[7:0]};
                CFG_RD_HALT_ADDR:    data_o = CVA6Cfg.HaltAddress;
                CFG_RD_EXC_ADDR:     data_o = CVA6Cfg.ExceptionAddress;
                CFG_RD_DM_BASE:      data_o = CVA6Cfg.DmBaseAddress;
                default:             err_o  = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/cva6_cfg_reader.sv
// Read-only burst responder for the elaborated configuration: clk_i/rst_ni, flush_i, req_* in, rsp_* out.
// Latency: first beat registered 1 cycle after request accept; 1 beat/cycle thereafter.
// Backpressure: output register holds while rsp_ready_i is low; requests only accepted in IDLE with a free output slot.
module cva6_cfg_reader
    import config_pkg::*;
#(
    parameter cva6_cfg_t CVA6Cfg = cva6_cfg_empty
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [7:0]  req_addr_i,
    input  logic [4:0]  req_len_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        rsp_last_o
);

    rd_state_e   state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [4:0]  rem_q, rem_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_last_q, rsp_last_d;

    logic [7:0]  lut_addr;
    logic [63:0] lut_data;
    logic        lut_err;
    logic        req_hs;
    logic        rsp_hs;

    // In IDLE the lookup serves the incoming request; in STREAM it serves the next burst word.
    assign lut_addr = (state_q == RD_IDLE) ? req_addr_i : addr_q;

    cva6_cfg_word_lut #(
        .CVA6Cfg(CVA6Cfg)
    ) u_lut (
        .addr_i(lut_addr),
        .data_o(lut_data),
        .err_o (lut_err)
    );

    // Flush gating keeps the handshake definition honest: nothing is accepted in a flush cycle.
    assign req_ready_o = (state_q == RD_IDLE) && (!rsp_valid_q || rsp_ready_i) && !flush_i;
    assign req_hs      = req_valid_i && req_ready_o;
    assign rsp_hs      = rsp_valid_q && rsp_ready_i;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_last_d  = rsp_last_q;

        if (flush_i) begin
            state_d     = RD_IDLE;
            rsp_valid_d = 1'b0;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b0;
            rsp_last_d  = 1'b0;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    if (req_hs) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = lut_data;
                        rsp_err_d   = lut_err;
                        rsp_last_d  = (req_len_i == 5'd0);
                        addr_d      = req_addr_i + 8'd1;
                        rem_d       = req_len_i;
                        state_d     = (req_len_i != 5'd0) ? RD_STREAM : RD_IDLE;
                    end else if (rsp_hs) begin
                        rsp_valid_d = 1'b0;
                    end
                end
                RD_STREAM: begin
                    // rem_q counts beats still to load; it is never 0 here.
                    if (rsp_hs) begin
                        rsp_data_d = lut_data;
                        rsp_err_d  = lut_err;
                        rsp_last_d = (rem_q == 5'd1);
                        addr_d     = addr_q + 8'd1;
                        rem_d      = rem_q - 5'd1;
                        if (rem_q == 5'd1) state_d = RD_IDLE;
                    end
                end
                default: state_d = RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RD_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_last_o  = rsp_last_q;

endmodule
